uart_tx_arbiter: RTL

//  Shares one uart_tx byte transmitter between NR_REQ requesters (debug, status, capture dump).

---
 rtl/uart_tx_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one uart_tx byte transmitter between NR_REQ requesters using a
//   round-robin grant. Once a requester wins, the grant stays locked to it
//   until the byte flagged as message-final has been accepted, so messages
//   from different requesters never interleave on the line.
//
// Parameters
//   NR_REQ   number of requesters (>= 2); grant id width IDW = $clog2(NR_REQ)
//   TIMEOUT  idle cycles allowed in HOLD before the lock is dropped
//            (only used when UART_TX_ARB_TIMEOUT_EN is defined)
//
// Optional feature macro
//   UART_TX_ARB_TIMEOUT_EN : enables the HOLD watchdog and the timeout pulse.
//                            Undefined: HOLD waits forever, timeout is 0.
//
// Ports
//   clk       in   clock, all logic on posedge
//   reset     in   synchronous active-high reset
//   req       in   per-requester byte request, held until ack
//   data      in   byte of requester i at data[8*i+7:8*i]
//   last      in   byte is the final byte of the requester's message
//   ack       out  one-cycle pulse: byte of requester i accepted
//   busy      out  arbiter not idle
//   grant_id  out  currently granted requester (valid while busy)
//   timeout   out  one-cycle pulse: lock dropped by watchdog
//   tx_req    out  request to uart_tx, held until tx_ready
//   tx_data   out  byte to uart_tx, stable while tx_req
//   tx_ready  in   uart_tx accept pulse
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NR_REQ  = 4,
  parameter int TIMEOUT = 1000000,
  localparam int IDW    = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NR_REQ-1:0]     req,
  input  logic [8*NR_REQ-1:0]   data,
  input  logic [NR_REQ-1:0]     last,
  output logic [NR_REQ-1:0]     ack,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id,
  output logic                  timeout,
  output logic                  tx_req,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t              state_q;
  logic [IDW-1:0]      ptr_q;
  logic [IDW-1:0]      grant_q;
  logic                last_q;
  logic                tx_req_q;
  logic [7:0]          tx_data_q;
  logic [NR_REQ-1:0]   ack_q;
  logic                busy_q;

  logic                win_found_s;
  logic [IDW-1:0]      win_id_s;

  // Successor of a requester id, wrapping NR_REQ-1 back to 0.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    if (id == IDW'(NR_REQ - 1)) begin
      return {IDW{1'b0}};
    end else begin
      return IDW'(id + 1'b1);
    end
  endfunction

  // Round-robin pick: first set request at or after the pointer, wrapping.
  always_comb begin
    int idx;
    win_found_s = 1'b0;
    win_id_s    = {IDW{1'b0}};
    for (int i = 0; i < NR_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NR_REQ;
      if (!win_found_s && req[idx]) begin
        win_found_s = 1'b1;
        win_id_s    = IDW'(idx);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q;
  logic          timeout_q;
`endif

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= {IDW{1'b0}};
      grant_q   <= {IDW{1'b0}};
      last_q    <= 1'b0;
      tx_req_q  <= 1'b0;
      tx_data_q <= 8'h00;
      ack_q     <= {NR_REQ{1'b0}};
      busy_q    <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_q     <= {CW{1'b0}};
      timeout_q <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      ack_q <= {NR_REQ{1'b0}};
`ifdef UART_TX_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (win_found_s) begin
            grant_q   <= win_id_s;
            tx_data_q <= data[8*win_id_s +: 8];
            last_q    <= last[win_id_s];
            tx_req_q  <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= SEND;
          end
        end
        SEND: begin
          // Requests are deliberately ignored here; only tx_ready matters.
          if (tx_ready) begin
            tx_req_q       <= 1'b0;
            ack_q[grant_q] <= 1'b1;
            state_q        <= ACK;
          end
        end
        ACK: begin
          if (last_q) begin
            ptr_q   <= next_id(grant_q);
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_q   <= {CW{1'b0}};
`endif
            state_q <= HOLD;
          end
        end
        HOLD: begin
          // Locked: only the granted requester may continue its message.
          if (req[grant_q]) begin
            tx_data_q <= data[8*grant_q +: 8];
            last_q    <= last[grant_q];
            tx_req_q  <= 1'b1;
            state_q   <= SEND;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            ptr_q     <= next_id(grant_q);
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= CW'(cnt_q + 1'b1);
          end
`endif
        end
        default: begin
          tx_req_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign ack      = ack_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;
  assign tx_req   = tx_req_q;
  assign tx_data  = tx_data_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  // No watchdog in this build; the expression is constant 0 and keeps
  // TIMEOUT referenced so the parameter list is identical in both builds.
  assign timeout = (TIMEOUT < 0) ? 1'b1 : 1'b0;
`endif

endmodule
